// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Covers the status-pin bit map and the pointer-width helper.
`default_nettype none

package fifo_pkg;

    localparam int STAT_EMPTY        = 0;
    localparam int STAT_FULL         = 1;
    localparam int STAT_UNDERFLOW    = 2;
    localparam int STAT_OVERFLOW     = 3;
    localparam int STAT_ALMOST_EMPTY = 4;
    localparam int STAT_ALMOST_FULL  = 5;

    // One extra bit beyond the address width acts as the wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with a synchronous write and a registered read.
// Only the read-data register is reset; the storage array is not.
`default_nettype none

module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the slot being written in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky errors.
// The top level owns the pointers, flags and error logic; storage lives in fifo_mem.
`default_nettype none

module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int AE_THRESH = 2,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic                      rd_valid_o,
    output logic [ptr_w(DEPTH)-1:0]   count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      almost_empty_o,
    output logic                      almost_full_o,
    output logic                      overflow_o,
    output logic                      underflow_o,
    input  logic                      clr_err_i
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [PW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;
    logic          w_wr_acc;

    assign w_count  = wr_ptr_q - rd_ptr_q;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == DEPTH_C);
    assign w_rd_acc = rd_en_i && !w_empty;
    // When full, a concurrent accepted read frees the slot this write lands in.
    assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(w_wr_acc);
        rd_ptr_d    = rd_ptr_q + PW'(w_rd_acc);
        overflow_d  = (wr_en_i && !w_wr_acc) || (overflow_q && !clr_err_i);
        underflow_d = (rd_en_i && !w_rd_acc) || (underflow_q && !clr_err_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= w_rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_wr_acc && !reset),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data_i),
        .re_i    (w_rd_acc && !reset),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o     = rd_valid_q;
    assign count_o        = w_count;
    assign empty_o        = w_empty;
    assign full_o         = w_full;
    assign almost_empty_o = (w_count <= AE_C);
    assign almost_full_o  = (w_count >= AF_C);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with a queue scoreboard and a cycle-level reference model.
`default_nettype none

module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AE_T  = 2;
    localparam int AF_T  = DEPTH - 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [5:0]       count;
    logic             empty, full, almost_empty, almost_full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb_q [$];
    int               m_count;
    logic             m_ovf, m_unf, m_valid;
    logic [WIDTH-1:0] m_rd_data;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AE_THRESH (AE_T),
        .AF_THRESH (AF_T)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full),
        .almost_empty_o (almost_empty),
        .almost_full_o  (almost_full),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .clr_err_i      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        check("count", 32'(count), 32'(m_count));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("full", 32'(full), 32'(m_count == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= AE_T));
        check("almost_full", 32'(almost_full), 32'(m_count >= AF_T));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus; the model predicts the state after the edge.
    task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic clr);
        logic racc, wacc;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        clr_err = clr;
        racc = rd && (m_count != 0);
        wacc = wr && ((m_count != DEPTH) || racc);
        m_valid = racc;
        if (racc) begin
            m_rd_data = sb_q.pop_front();
            m_count--;
        end
        if (wacc) begin
            sb_q.push_back(wd);
            m_count++;
        end
        m_ovf = (wr && !wacc) || (m_ovf && !clr);
        m_unf = (rd && !racc) || (m_unf && !clr);
        @(posedge clk);
        #1;
        check_all();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb_q.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_valid   = 1'b0;
        m_rd_data = '0;
        repeat (n) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        @(posedge clk);
        do_reset(2);

        // Fill and drain
        for (int i = 0; i < 32; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Wrap-around past the end of the storage array
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b1, WIDTH'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Underflow, clear, overflow, clear-with-rejected-write
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check("ovf_sticky_vs_clr", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Simultaneous read+write while full, then drain
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_rw_oldest", 32'(rd_data), 32'h0000_00C0);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous read+write while empty: no bypass
        step(1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("empty_rw_data", 32'(rd_data), 32'h0000_0055);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-stream
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        do_reset(1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_reset_data", 32'(rd_data), 32'h0000_005A);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next generation of the team's single-clock byte FIFO, generalised in data width, depth and almost-flag thresholds. It adds correct pointer wrap-around, an occupancy count, same-cycle read+write and sticky error flags with explicit clear. It sits between the pad-level input bus and the downstream consumer. Its status flags pack onto the bidirectional status pins through the shared bit map.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `DEPTH`, default 32: number of entries; power of two, ≥4.
- `AE_THRESH`, default 2: `almost_empty` asserts when count ≤ AE_THRESH.
- `AF_THRESH`, default DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write request.
- `wr_data` in WIDTH: write data.
- `rd_en` in 1: read request.
- `rd_data` out WIDTH: registered read data.
- `rd_valid` out 1: `rd_data` updated this cycle by an accepted read.
- `count` out clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `empty`, `full`, `almost_empty`, `almost_full` out 1 each: occupancy flags.
- `overflow`, `underflow` out 1 each: sticky error flags.
- `clr_err` in 1: clears sticky error flags.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are clog2(DEPTH)+1 bits wide, and the MSB is the wrap bit.
- `count` = wr_ptr − rd_ptr, modulo 2^(clog2(DEPTH)+1).
- `empty` = (count==0). `full` = (count==DEPTH). Both almost flags are comparisons on `count`, all combinational from registered state.
- Read accept: `rd_en && !empty`. Mem[rd_ptr] goes to `rd_data`, `rd_ptr`+1, and `rd_valid`=1 next cycle.
- Write accept: `wr_en && (!full || read accepted this cycle)`. wr_data goes to mem[wr_ptr], `wr_ptr`+1.
- Simultaneous accepted read and write: `count` unchanged.
  - When full, the write is accepted because a slot frees.
  - When empty, there is no bypass. The read is rejected and underflow is flagged, while the write is accepted.
- Rejected `wr_en` sets `overflow`. Rejected `rd_en` sets `underflow`.
  - Both flags hold until `clr_err`.
  - If a set condition and `clr_err` occur in the same cycle, set wins.
- Pointers wrap naturally past DEPTH−1. No entry is lost or duplicated across wrap.
- `rd_data` holds its last value when no read is accepted.
- Memory contents are not reset.

## Timing
- All state updates on posedge `clk`. `reset` dominates every other input.
- Reset values:
  - `rd_data`=0, `rd_valid`=0, `count`=0.
  - `empty`=1, `almost_empty`=1.
  - `full`, `almost_full`, `overflow`, `underflow` = 0.
- Reset mid-operation discards all entries: pointers go to 0 on that edge.
- Read latency: `rd_en` sampled at edge k, then `rd_data`/`rd_valid` valid after edge k, for one cycle.
- Write-to-read: a word written at edge k makes `empty`=0 after edge k. The earliest read accept is at edge k+1, with data visible after k+1.
- Flags and `count` reflect the state after the most recent edge; there is no extra lag.

## Structure
- `fifo_pkg` holds:
  - status bit indices EMPTY=0, FULL=1, UNDERFLOW=2, OVERFLOW=3, ALMOST_EMPTY=4, ALMOST_FULL=5;
  - a pointer-width helper, `ptr_w(DEPTH)` = clog2(DEPTH)+1.
- Sub-module `fifo_mem` is a simple dual-port RAM, WIDTH×DEPTH, with synchronous write and registered read. The top level owns pointers, count, flags and error logic.
- Elaboration checks reject a non-power-of-two DEPTH and AE_THRESH ≥ AF_THRESH.

## Test plan
- **Reset, then idle:** reset=1 for 2 cycles → count=0, empty=1, almost_empty=1, all others 0.
- **Fill and drain:** write 0x00..0x1F (32 words) → full=1 and almost_full=1 from count 30. Then read 32 words → rd_data 0x00..0x1F in order, with rd_valid each cycle; empty=1 at the end.
- **Wrap-around:**
  - write 20, read 20, write 32 words 0xA0..0xBF → full=1.
  - Read all → 0xA0..0xBF in order, no duplicates.
- **Overflow/underflow:**
  - wr_en when full → overflow=1, count stays 32.
  - rd_en when empty → underflow=1, rd_valid=0.
  - clr_err → both clear.
  - clr_err with a concurrent rejected write → overflow stays 1.
- **Simultaneous read+write:**
  - When full, wr_en+rd_en → count stays 32, overflow=0, and the oldest word is output.
  - When empty with wr 0x55: underflow=1, count=1, then the next read returns 0x55.
- **Reset mid-stream:** after 10 writes and 3 reads, pulse reset → count=0, empty=1, and the next write/read pair returns the new data.
